seg7_class_disp: RTL

Parametrised two-digit Pmod SSD (common cathode) driver that displays a CNN class index as a decimal number, "00" to "99".
- A class result is captured on a valid strobe.
- The result is converted to BCD by an iterative double-dabble sub-block.
- The two digits are time-multiplexed through one shared segment bus plus a 1-bit digit select.
- Sits after the classifier output stage. Replaces the fixed 0/1 display and supports any class count up to 2^CLASS_W.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/seg7_class_disp.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit class display: segment patterns,
// the digit decoder and the control FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  // Active-high {a,b,c,d,e,f,g} patterns for the decimal digits 0..9
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  // Non-decimal nibbles decode to a dark digit
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_DIGIT[0];
      4'd1:    pat = SEG_DIGIT[1];
      4'd2:    pat = SEG_DIGIT[2];
      4'd3:    pat = SEG_DIGIT[3];
      4'd4:    pat = SEG_DIGIT[4];
      4'd5:    pat = SEG_DIGIT[5];
      4'd6:    pat = SEG_DIGIT[6];
      4'd7:    pat = SEG_DIGIT[7];
      4'd8:    pat = SEG_DIGIT[8];
      4'd9:    pat = SEG_DIGIT[9];
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per clock,
// CLASS_W steps in total. The first step is taken on the start cycle
// itself, so oDone pulses CLASS_W-1 cycles after iStart and oBcd holds
// the result until the next start.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int CLASS_W = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               iStart,
  input  logic [CLASS_W-1:0] iBin,
  output logic               oDone,
  output logic [11:0]        oBcd
);

  logic [CLASS_W-1:0] bin_q;
  logic [11:0]        bcd_q;
  logic [3:0]         cnt_q;
  logic               done_q;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in a bit
  function automatic logic [11:0] dabble(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[10:0], bit_in};
  endfunction

  // Load on start, then step until the remaining-iteration count runs out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (iStart) begin
      bcd_q  <= dabble(12'd0, iBin[CLASS_W-1]);
      bin_q  <= iBin << 1;
      cnt_q  <= 4'(CLASS_W - 1);
      done_q <= (CLASS_W == 1);
    end else if (cnt_q != 4'd0) begin
      bcd_q  <= dabble(bcd_q, bin_q[CLASS_W-1]);
      bin_q  <= bin_q << 1;
      cnt_q  <= cnt_q - 4'd1;
      done_q <= (cnt_q == 4'd1);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign oDone = done_q;
  assign oBcd  = bcd_q;

endmodule

// File: rtl/seg7_class_disp.sv
// Two-digit multiplexed seven-segment driver showing a class index as a
// decimal number "00".."99" ("--" when the value needs a hundreds digit).
// Optional macro SEG7_BLINK_EN: blink the display for 2 s after each new
// result (0.25 s on / 0.25 s off); without it the display is steady.
module seg7_class_disp
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int CLASS_W    = 7,
  parameter bit LEAD_ZERO  = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               iValid,
  input  logic [CLASS_W-1:0] iClass,
  input  logic               iBlank,
  output logic [6:0]         oSeg,
  output logic               oC,
  output logic               oBusy
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("seg7_class_disp: CLK_HZ/REFRESH_HZ must be at least 2");
    end
    if (CLASS_W < 1 || CLASS_W > 8) begin : g_bad_width
      $error("seg7_class_disp: CLASS_W must be within 1..8");
    end
  endgenerate

  state_t           state, next_state;
  logic             accept, load;
  logic             bcd_done;
  logic [11:0]      bcd;
  logic [3:0]       tens, units;
  logic             ovf;
  logic [CNT_W-1:0] ref_cnt;
  logic             sel;
  logic [6:0]       digit_pat;
  logic             blink_off;

  bin2bcd_seq #(.CLASS_W(CLASS_W)) u_bcd (
    .clk    (clk),
    .rstn   (rstn),
    .iStart (accept),
    .iBin   (iClass),
    .oDone  (bcd_done),
    .oBcd   (bcd)
  );

  // Control state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Accept a strobe only when idle, wait for the converter, then load once
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: if (iValid) begin
        accept     = 1'b1;
        next_state = CONV;
      end
      CONV: if (bcd_done) next_state = LOAD;
      LOAD: begin
        load       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign oBusy = (state != IDLE);

  // Displayed digits change only in the LOAD cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tens  <= 4'd0;
      units <= 4'd0;
      ovf   <= 1'b0;
    end else if (load) begin
      tens  <= bcd[7:4];
      units <= bcd[3:0];
      ovf   <= (bcd[11:8] != 4'd0);
    end
  end

  // Refresh divider: toggle the digit slot every DIV cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_cnt <= '0;
      sel     <= 1'b0;
    end else if (ref_cnt == CNT_W'(DIV - 1)) begin
      ref_cnt <= '0;
      sel     <= ~sel;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Pattern for the digit slot currently selected
  always_comb begin
    digit_pat = SEG_BLANK;
    if (ovf)                             digit_pat = SEG_DASH;
    else if (sel)                        digit_pat = seg_decode(units);
    else if (tens == 4'd0 && !LEAD_ZERO) digit_pat = SEG_BLANK;
    else                                 digit_pat = seg_decode(tens);
  end

`ifdef SEG7_BLINK_EN
  localparam int QTR   = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 2;
  localparam int QTR_W = $clog2(QTR);

  logic             blink_act;
  logic [QTR_W-1:0] blink_cnt;
  logic [2:0]       blink_qtr;

  // Eight quarter-second phases after each load; odd phases are dark
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_act <= 1'b0;
      blink_cnt <= '0;
      blink_qtr <= '0;
    end else if (load) begin
      blink_act <= 1'b1;
      blink_cnt <= '0;
      blink_qtr <= '0;
    end else if (blink_act) begin
      if (blink_cnt == QTR_W'(QTR - 1)) begin
        blink_cnt <= '0;
        blink_qtr <= blink_qtr + 3'd1;
        if (blink_qtr == 3'd7) blink_act <= 1'b0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_act & blink_qtr[0];
`else
  assign blink_off = 1'b0;
`endif

  // Registered outputs; they trail sel by one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oSeg <= SEG_BLANK;
      oC   <= 1'b0;
    end else begin
      oC   <= sel;
      oSeg <= (iBlank || blink_off) ? SEG_BLANK : digit_pat;
    end
  end

endmodule
